plantard_shift_mlane: RTL and testbench



---
 rtl/plantard_shift_mlane_pkg.sv | 24 ++
 rtl/plantard_shift_lane.sv | 58 +++++
 rtl/plantard_shift_mlane.sv | 97 +++++++++
 tb/tb_plantard_shift_mlane.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plantard_shift_mlane_pkg.sv
// Shared constants, types and helpers for the multi-lane Plantard shift reducer.
package plantard_pkg;

  // Register stages from input capture to the output register.
  localparam int PLANTARD_MLANE_LAT = 4;

  // The config record is sized for the widest supported build (LOGQ <= 64,
  // LOGK <= 8); narrower builds use the low bits of each field.
  localparam int CFG_QW = 64;
  localparam int CFG_KW = 8;

  typedef struct packed {
    logic [CFG_QW-1:0] q;
    logic [CFG_KW-1:0] k1;
    logic [CFG_KW-1:0] k2;
  } plantard_cfg_t;

  // Intermediate width LOGQ + 2^LOGK + 1; the top bit is a guard bit, the
  // reduction itself wraps at one bit less.
  function automatic int plantard_w(input int logq, input int logk);
    return logq + (1 << logk) + 1;
  endfunction

endpackage

// File: rtl/plantard_shift_lane.sv
// One lane of the shift-based Plantard reduction: capture, shift, add/sub,
// sum + T==Q correction. No handshake here; every register follows en.
module plantard_shift_lane
  import plantard_pkg::*;
#(
  parameter int LOGQ    = 64,
  parameter int LOGK    = 8,
  parameter int CORRECT = 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic [2*LOGQ-1:0] c,
  input  logic [LOGQ-1:0]   q,
  input  logic [LOGK-1:0]   k1,
  input  logic [LOGK-1:0]   k2,
  output logic [LOGQ-1:0]   t
);
  // Arithmetic is modulo 2^(LOGQ+KMAX+1): drop the guard bit of the width.
  localparam int MW = plantard_w(LOGQ, LOGK) - 1;

  logic [LOGQ-1:0] ch1, ch2;
  logic [MW-1:0]   sh_a, sh_b, dif3, add3, s4;
  logic [LOGQ-1:0] t2;

  // Only the high half of C feeds the reduction.
  logic unused_lo;
  assign unused_lo = ^c[LOGQ-1:0];

  // Stage 1: capture CH.
  always_ff @(posedge clk)
    if (en) ch1 <= c[2*LOGQ-1:LOGQ];

  // Stage 2: the two shifted copies of CH.
  always_ff @(posedge clk)
    if (en) begin
      sh_a <= MW'(ch1) << k1;
      sh_b <= MW'(ch1) << k2;
      ch2  <= ch1;
    end

  // Stage 3: split the four-term sum into two pairs.
  always_ff @(posedge clk)
    if (en) begin
      dif3 <= sh_a - sh_b;
      add3 <= MW'(ch2) + MW'(q);
    end

  // Final sum and the upper-half extraction feeding the output register.
  always_comb begin
    s4 = dif3 + add3;
    t2 = LOGQ'(s4 >> LOGQ);
  end

  // Stage 4: optional T==Q -> 0 correction into the output register.
  always_ff @(posedge clk)
    if (en) t <= ((CORRECT != 0) && (t2 == q)) ? '0 : t2;

endmodule

// File: rtl/plantard_shift_mlane.sv
// NLANE-wide Plantard shift reducer: shared config, valid/tag pipeline,
// in-flight counter guarding config writes, and the lane array.
module plantard_shift_mlane
  import plantard_pkg::*;
#(
  parameter int LOGQ    = 64,
  parameter int LOGK    = 8,
  parameter int NLANE   = 4,
  parameter int TAGW    = 8,
  parameter int CORRECT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [LOGQ-1:0]         cfg_q,
  input  logic [LOGK-1:0]         cfg_k1,
  input  logic [LOGK-1:0]         cfg_k2,
  output logic                    cfg_ready,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NLANE*2*LOGQ-1:0] in_data,
  input  logic [TAGW-1:0]         in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NLANE*LOGQ-1:0]   out_data,
  output logic [TAGW-1:0]         out_tag,
  output logic                    busy
);
  localparam int LAT = PLANTARD_MLANE_LAT;
  localparam int CW  = $clog2(LAT + 1);

  logic                           en, acc, ret, cfg_acc;
  logic [LAT:1]                   vld_pipe;
  logic [LAT:1][TAGW-1:0]         tag_pipe;
  logic [CW-1:0]                  cnt;
  plantard_cfg_t                  cfg_r;
  logic [LOGQ-1:0]                q_cur;
  logic [LOGK-1:0]                k1_cur, k2_cur;
  logic [NLANE-1:0][2*LOGQ-1:0]   lane_c;
  logic [NLANE-1:0][LOGQ-1:0]     lane_t;

  // Whole pipe freezes only when the output holds data nobody takes.
  assign en        = !(out_valid && !out_ready);
  assign cfg_ready = (cnt == '0);
  assign busy      = (cnt != '0);
  assign cfg_acc   = cfg_we && cfg_ready;
  // Held low during reset; a config write steals the input slot.
  assign in_ready  = rst && en && !cfg_acc;
  assign acc       = in_valid && in_ready;
  assign ret       = out_valid && out_ready;
  assign out_valid = vld_pipe[LAT];
  assign out_tag   = tag_pipe[LAT];

  assign q_cur  = cfg_r.q[LOGQ-1:0];
  assign k1_cur = cfg_r.k1[LOGK-1:0];
  assign k2_cur = cfg_r.k2[LOGK-1:0];

  assign lane_c   = in_data;
  assign out_data = lane_t;

  // Valid bits shift with the data; bubbles are kept.
  always_ff @(posedge clk or negedge rst)
    if (!rst)    vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[LAT-1:1], acc};

  // Tags ride alongside the lane data; no reset needed.
  always_ff @(posedge clk)
    if (en) tag_pipe <= {tag_pipe[LAT-1:1], in_tag};

  // In-flight count: +1 on accept, -1 on retire, unchanged on both.
  always_ff @(posedge clk or negedge rst)
    if (!rst)               cnt <= '0;
    else if (acc && !ret)   cnt <= cnt + CW'(1);
    else if (!acc && ret)   cnt <= cnt - CW'(1);

  // Config only changes with an empty pipe, so lanes read it directly.
  always_ff @(posedge clk or negedge rst)
    if (!rst) cfg_r <= '0;
    else if (cfg_acc) begin
      cfg_r.q  <= CFG_QW'(cfg_q);
      cfg_r.k1 <= CFG_KW'(cfg_k1);
      cfg_r.k2 <= CFG_KW'(cfg_k2);
    end

  plantard_shift_lane #(
    .LOGQ(LOGQ), .LOGK(LOGK), .CORRECT(CORRECT)
  ) u_lane [NLANE-1:0] (
    .clk (clk),
    .en  (en),
    .c   (lane_c),
    .q   (q_cur),
    .k1  (k1_cur),
    .k2  (k2_cur),
    .t   (lane_t)
  );

endmodule

// File: tb/tb_plantard_shift_mlane.sv
// Bench for plantard_shift_mlane: directed table, handshake corner cases and
// randomized traffic against an arithmetic reference, CORRECT=1 and CORRECT=0.
module tb_plantard_shift_mlane;
  localparam int LQ = 16, LK = 4, NL = 4, TW = 8;
  localparam int MODW = LQ + (1 << LK);   // LOGQ + KMAX + 1
  localparam int DW = NL * 2 * LQ, OW = NL * LQ;

  typedef longint unsigned u64;

  logic clk = 1'b0, rst = 1'b0;
  logic cfg_we = 1'b0;
  logic [LQ-1:0] cfg_q = '0;
  logic [LK-1:0] cfg_k1 = '0, cfg_k2 = '0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [TW-1:0] in_tag = '0;
  logic cfg_ready, in_ready, out_valid, busy;
  logic [OW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic cfg_ready0, in_ready0, out_valid0, busy0;
  logic [OW-1:0] out_data0;
  logic [TW-1:0] out_tag0;

  plantard_shift_mlane #(.LOGQ(LQ), .LOGK(LK), .NLANE(NL), .TAGW(TW), .CORRECT(1)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_k1(cfg_k1), .cfg_k2(cfg_k2),
    .cfg_ready(cfg_ready), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .busy(busy));

  plantard_shift_mlane #(.LOGQ(LQ), .LOGK(LK), .NLANE(NL), .TAGW(TW), .CORRECT(0)) dut0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_k1(cfg_k1), .cfg_k2(cfg_k2),
    .cfg_ready(cfg_ready0), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .in_tag(in_tag), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_tag(out_tag0), .busy(busy0));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_ret = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: S = (CH<<K1) - (CH<<K2) + CH + Q mod 2^MODW, T2 = S>>LOGQ.
  function automatic logic [LQ-1:0] ref_lane(input logic [LQ-1:0] ch, input logic [LQ-1:0] q,
                                             input int k1, input int k2, input bit corr);
    u64 s, m;
    logic [LQ-1:0] t2;
    m  = (u64'(1) << MODW) - 1;
    s  = ((u64'(ch) << k1) - (u64'(ch) << k2) + u64'(ch) + u64'(q)) & m;
    t2 = LQ'(s >> LQ);
    return (corr && t2 == q) ? '0 : t2;
  endfunction

  function automatic logic [OW-1:0] ref_word(input logic [DW-1:0] d, input logic [LQ-1:0] q,
                                             input int k1, input int k2, input bit corr);
    logic [OW-1:0] r;
    for (int i = 0; i < NL; i++)
      r[i*LQ +: LQ] = ref_lane(d[i*2*LQ+LQ +: LQ], q, k1, k2, corr);
    return r;
  endfunction

  // Same CH in every lane, random low halves (they must not matter).
  function automatic logic [DW-1:0] rep_ch(input logic [LQ-1:0] ch);
    logic [DW-1:0] d;
    for (int i = 0; i < NL; i++) d[i*2*LQ +: 2*LQ] = {ch, LQ'($urandom)};
    return d;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < NL; i++)
      d[i*2*LQ +: 2*LQ] = {(($urandom % 4) == 0) ? {LQ{1'b1}} : LQ'($urandom), LQ'($urandom)};
    return d;
  endfunction

  // Scoreboard and shadow configuration.
  typedef struct { logic [OW-1:0] t1; logic [OW-1:0] t0; logic [TW-1:0] tag; } exp_t;
  exp_t sb[$];
  logic [LQ-1:0] sq = '0;
  int sk1 = 0, sk2 = 0;
  bit stall_prev = 1'b0;
  logic [OW-1:0] prev_data;
  logic [TW-1:0] prev_tag;

  // Monitor: sample handshakes mid-cycle, predict control outputs from the
  // scoreboard occupancy, check retired data in order.
  initial forever begin
    @(negedge clk);
    if (mon_en && rst) begin
      bit   cok;
      exp_t e;
      cok = (sb.size() == 0);
      chk("cfg_ready", cfg_ready, cok);
      chk("busy", busy, !cok);
      chk("in_ready", in_ready, !(out_valid && !out_ready) && !(cfg_we && cok));
      if (stall_prev) begin
        chk("stall_vld", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_tag", out_tag, prev_tag);
      end
      if (out_valid && out_ready) begin
        n_ret++;
        if (sb.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          e = sb.pop_front();
          chk("data_c1", out_data, e.t1);
          chk("data_c0", out_data0, e.t0);
          chk("tag", out_tag, e.tag);
          chk("vld_c0", out_valid0, 1);
        end
      end
      if (in_valid && in_ready) begin
        e.t1 = ref_word(in_data, sq, sk1, sk2, 1'b1);
        e.t0 = ref_word(in_data, sq, sk1, sk2, 1'b0);
        e.tag = in_tag;
        sb.push_back(e);
      end
      if (cfg_we && cok) begin
        sq = cfg_q; sk1 = int'(cfg_k1); sk2 = int'(cfg_k2);
      end
      stall_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_tag = out_tag;
    end
  end

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (sb.size() != 0 && n < 40) begin tick(); n++; end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic cfg_write(input logic [LQ-1:0] q, input int k1, input int k2);
    cfg_we = 1'b1; cfg_q = q; cfg_k1 = LK'(k1); cfg_k2 = LK'(k2);
    #1;
    chk("cfg_in_ready", in_ready, 0);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send_one(input logic [DW-1:0] d, input logic [TW-1:0] tg,
                          output logic [OW-1:0] r1, output logic [OW-1:0] r0, output int lat);
    in_valid = 1'b1; in_data = d; in_tag = tg;
    #1;
    chk("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin tick(); lat++; end
    r1 = out_data; r0 = out_data0;
    chk("send_tag", out_tag, tg);
  endtask

  typedef struct { logic [LQ-1:0] q; int k1; int k2; logic [LQ-1:0] ch, e1, e0; } vec_t;
  vec_t vt[10];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] r1, r0;
    int lat, sent, base, n;
    bit fire;

    vt[0] = '{16'hFFF1,  4,  0, 16'h0001, 16'h0001, 16'h0001};
    vt[1] = '{16'hFFF1,  4,  0, 16'h0000, 16'h0000, 16'h0000};
    vt[2] = '{16'h0001,  0,  0, 16'hFFFF, 16'h0000, 16'h0001};
    vt[3] = '{16'h0000,  0,  0, 16'h0000, 16'h0000, 16'h0000};
    vt[4] = '{16'h0000,  0, 15, 16'h0001, 16'hFFFF, 16'hFFFF};
    vt[5] = '{16'hFFFF, 15,  0, 16'hFFFF, 16'h8000, 16'h8000};
    vt[6] = '{16'h0101,  8,  4, 16'h1234, 16'h0011, 16'h0011};
    vt[7] = '{16'hFFFF, 15, 15, 16'hFFFF, 16'h0001, 16'h0001};
    vt[8] = '{16'h0002,  1,  0, 16'hFFFF, 16'h0000, 16'h0002};
    vt[9] = '{16'h0000, 15,  0, 16'hFFFF, 16'h7FFF, 16'h7FFF};

    // Reset held with traffic and a config write pending.
    in_valid = 1'b1; cfg_we = 1'b1; cfg_q = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; cfg_we = 1'b0;
    #2 rst = 1'b1;
    mon_en = 1'b1;
    tick();

    // Basic two-lane case.
    cfg_write(16'hFFF1, 4, 0);
    send_one({32'h0, 32'h0, 32'h0, 32'h0001_0000}, 8'h5A, r1, r0, lat);
    chk("basic_lat", lat, 4);
    chk("basic_t0", r1[0 +: LQ], 16'h0001);
    chk("basic_t1", r1[LQ +: LQ], 16'h0000);
    drain();

    // Table of hand-derived vectors, both correction settings.
    for (int v = 0; v < 10; v++) begin
      cfg_write(vt[v].q, vt[v].k1, vt[v].k2);
      send_one(rep_ch(vt[v].ch), TW'(v), r1, r0, lat);
      chk("vec_lat", lat, 4);
      for (int i = 0; i < NL; i++) begin
        chk("vec_c1", r1[i*LQ +: LQ], vt[v].e1);
        chk("vec_c0", r0[i*LQ +: LQ], vt[v].e0);
      end
      drain();
    end

    // Backpressure: 8 tags streamed, output stalled for cycles 6..9.
    cfg_write(16'hFFF1, 4, 0);
    sent = 0; base = n_ret;
    for (int c = 0; c < 40 && (sent < 8 || sb.size() != 0); c++) begin
      out_ready = !(c >= 6 && c <= 9);
      in_valid = (sent < 8); in_data = rand_data(); in_tag = TW'(sent);
      #1;
      if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
      fire = in_valid && in_ready;
      tick();
      if (fire) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", n_ret - base, 8);
    chk("bp_sb_empty", sb.size(), 0);

    // Config interlock: write ignored with 2 in flight, accepted once idle.
    drain();
    cfg_write(16'h0010, 15, 0);
    in_valid = 1'b1; in_data = rep_ch(16'h0001); in_tag = 8'hA0;
    tick();
    in_tag = 8'hA1;
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_q = 16'h9000; cfg_k1 = 4'd15; cfg_k2 = 4'd0;
    #1;
    chk("il_cfg_ready_busy", cfg_ready, 0);
    tick();
    cfg_we = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    chk("il_old_q", out_data[0 +: LQ], 16'h0000);
    drain();
    cfg_we = 1'b1; cfg_q = 16'h9000;
    #1;
    chk("il_cfg_ready_idle", cfg_ready, 1);
    chk("il_in_ready_low", in_ready, 0);
    tick();
    cfg_we = 1'b0;
    send_one(rep_ch(16'h0001), 8'hA2, r1, r0, lat);
    chk("il_new_q", r1[0 +: LQ], 16'h0001);
    chk("il_lat", lat, 4);
    drain();

    // Reset with 3 transactions in flight.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = rand_data(); in_tag = TW'(8'hC0 + i); tick(); end
    #1;
    rst = 1'b0; mon_en = 1'b0; sb.delete(); stall_prev = 1'b0;
    sq = '0; sk1 = 0; sk2 = 0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_cfg_ready", cfg_ready, 1);
    chk("mr_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mr_stale", out_valid, 0);
      chk("mr_busy_after", busy, 0);
    end
    // Config was cleared: Q=0, K1=K2=0 gives 0 for CH=FFFF.
    send_one(rep_ch(16'hFFFF), 8'hD0, r1, r0, lat);
    chk("mr_lat", lat, 4);
    chk("mr_cfg_cleared", r1, '0);
    drain();

    // Randomized traffic with random stalls and configurations.
    for (int b = 0; b < 200; b++) begin
      logic [LQ-1:0] q;
      int k1, k2;
      drain();
      q  = (($urandom % 4) == 0) ? LQ'($urandom_range(0, 3)) : LQ'($urandom);
      k1 = int'($urandom_range(0, 15));
      k2 = (($urandom % 4) == 0) ? k1 : int'($urandom_range(0, 15));
      cfg_write(q, k1, k2);
      sent = 0;
      for (int c = 0; c < 400 && sent < 50; c++) begin
        in_valid = (($urandom % 10) < 7); in_data = rand_data(); in_tag = TW'($urandom);
        out_ready = (($urandom % 4) != 0);
        #1;
        fire = in_valid && in_ready;
        tick();
        if (fire) sent++;
      end
      in_valid = 1'b0;
      chk("rand_batch_sent", sent, 50);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
